// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite blitter
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EVAL  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } blit_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [7:0] TRANSP_DEFAULT = 8'd7;

    localparam int ROM_AW = 11;
    localparam int FB_AW  = 19;

endpackage

// File: rtl/sprite_blitter_if.sv
// rtl/sprite_blitter_if.sv - draw request, sprite ROM and frame-buffer write signals
//
// master: the blitter (drives busy/done, rom_addr, fb_addr/fb_data/fb_we)
// slave : the environment (game logic request, ROM data, frame-buffer ready)
interface sprite_blitter_if;
    import sprite_pkg::*;

    logic              start;
    logic [9:0]        spr_x;
    logic [8:0]        spr_y;
    logic [ROM_AW-1:0] spr_base;
    logic              busy;
    logic              done;

    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    logic [FB_AW-1:0]  fb_addr;
    logic [7:0]        fb_data;
    logic              fb_we;
    logic              fb_ready;

    modport master (
        input  start, spr_x, spr_y, spr_base, rom_data, fb_ready,
        output busy, done, rom_addr, fb_addr, fb_data, fb_we
    );

    modport slave (
        output start, spr_x, spr_y, spr_base, rom_data, fb_ready,
        input  busy, done, rom_addr, fb_addr, fb_data, fb_we
    );

endinterface

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - screen clip flag and frame-buffer address for the current pixel
//
// Ports:
//   x, y     : latched sprite origin on screen
//   col, row : current pixel within the sprite
//   clipped  : pixel lies at or beyond the right or bottom screen edge
//   fb_addr  : sy*SCREEN_W + sx, meaningful only when clipped is low
module fb_addr_calc
    import sprite_pkg::*;
#(
    parameter int COL_W = 6,
    parameter int ROW_W = 6
) (
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    output logic             clipped,
    output logic [FB_AW-1:0] fb_addr
);

    // 11 bits so a sprite hanging off the edge never wraps back on screen.
    logic [10:0]      sx;
    logic [10:0]      sy;
    logic [FB_AW-1:0] sy_w;

    assign sx = 11'(x) + 11'(col);
    assign sy = 11'(y) + 11'(row);

    assign clipped = (sx >= 11'(SCREEN_W)) || (sy >= 11'(SCREEN_H));

    // 640 = 512 + 128; the upper bits of sx/sy only matter for the clip test.
    assign sy_w    = FB_AW'(sy[8:0]);
    assign fb_addr = (sy_w << 9) + (sy_w << 7) + FB_AW'(sx[9:0]);

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - copies opaque sprite ROM pixels into the frame buffer with clipping
//
// Ports:
//   Clk     : rising-edge clock
//   Reset_n : asynchronous active-low reset
//   bus     : sprite_blitter_if.master (draw request, busy/done, ROM read, FB write)
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int         SPR_W  = 48,
    parameter int         SPR_H  = 40,
    parameter logic [7:0] TRANSP = TRANSP_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    sprite_blitter_if.master bus
);

    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    blit_state_t       state;
    logic [9:0]        x_q;
    logic [8:0]        y_q;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [FB_AW-1:0]  fb_addr_q;
    logic [7:0]        fb_data_q;
    logic              fb_we_q;
    logic              busy_q;
    logic              done_q;

    logic              clipped;
    logic [FB_AW-1:0]  calc_addr;
    logic              last_col;
    logic              last_pixel;
    logic              skip;
    logic              advance;

    fb_addr_calc #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_addr_calc (
        .x       (x_q),
        .y       (y_q),
        .col     (col),
        .row     (row),
        .clipped (clipped),
        .fb_addr (calc_addr)
    );

    assign last_col   = (col == COL_W'(SPR_W - 1));
    assign last_pixel = last_col && (row == ROW_W'(SPR_H - 1));
    assign skip       = (bus.rom_data == TRANSP) || clipped;
    assign advance    = ((state == EVAL) && skip) || ((state == WRITE) && bus.fb_ready);

    // Pixels are walked row-major, so base + row*SPR_W + col is simply the
    // previous ROM address plus one; the pointer wraps at ROM_AW bits.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            col        <= '0;
            row        <= '0;
            rom_addr_q <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            fb_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_q        <= bus.spr_x;
                        y_q        <= bus.spr_y;
                        col        <= '0;
                        row        <= '0;
                        rom_addr_q <= bus.spr_base;
                        busy_q     <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: state <= EVAL;
                EVAL: begin
                    if (!skip) begin
                        fb_addr_q <= calc_addr;
                        fb_data_q <= bus.rom_data;
                        fb_we_q   <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.fb_ready) begin
                        fb_we_q <= 1'b0;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Common pixel-advance step, shared by the skip and write paths.
            if (advance) begin
                if (last_pixel) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end else begin
                    state      <= FETCH;
                    rom_addr_q <= rom_addr_q + ROM_AW'(1);
                    if (last_col) begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = fb_data_q;
    assign bus.fb_we    = fb_we_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard testbench for sprite_blitter
module tb_sprite_blitter;

    logic Clk;
    logic Reset_n;

    sprite_blitter_if bus ();

    sprite_blitter u_dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    logic [7:0] rom [0:2047];

    always @(posedge Clk) bus.rom_data <= rom[bus.rom_addr];

    // 0: fb_ready tied high, 1: random, 2: driven by the main sequence
    int ready_mode = 2;

    always @(negedge Clk) begin
        if (ready_mode == 0) bus.fb_ready = 1'b1;
        else if (ready_mode == 1) bus.fb_ready = ($urandom_range(0, 3) != 0);
    end

    logic [18:0] exp_addr [$];
    logic [7:0]  exp_data [$];
    int          exp_cost;
    int          exp_count;
    int          acc_edge;
    int          nwr;
    int          first_addr;
    int          last_addr;
    int          max_addr;
    bit          done_seen;
    int          done_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        #1;
        if (Reset_n) begin
            if (bus.fb_we && bus.fb_ready) begin
                nwr++;
                if (nwr == 1) first_addr = int'(bus.fb_addr);
                last_addr = int'(bus.fb_addr);
                if (int'(bus.fb_addr) > max_addr) max_addr = int'(bus.fb_addr);
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual_addr=%0d actual_data=%0d expected=none",
                             bus.fb_addr, bus.fb_data);
                end else begin
                    logic [18:0] ea;
                    logic [7:0]  ed;
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    check("write_addr", bus.fb_addr, ea);
                    check("write_data", bus.fb_data, ed);
                end
            end
            if (bus.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check("busy_during_done", bus.busy, 1);
            end
        end
    end

    // Reference: every sprite pixel, row-major; opaque on-screen pixels are
    // written and cost 3 cycles, everything else costs 2.
    task automatic begin_draw(input logic [9:0] x, input logic [8:0] y, input logic [10:0] b);
        int cost;
        cost = 0;
        exp_addr.delete();
        exp_data.delete();
        exp_count = 0;
        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < 48; c++) begin
                int a, sx, sy;
                logic [7:0] p;
                a  = (int'(b) + r * 48 + c) % 2048;
                p  = rom[a];
                sx = int'(x) + c;
                sy = int'(y) + r;
                if (p != 8'd7 && sx < 640 && sy < 480) begin
                    exp_addr.push_back(19'(sy * 640 + sx));
                    exp_data.push_back(p);
                    exp_count++;
                    cost += 3;
                end else begin
                    cost += 2;
                end
            end
        end
        exp_cost  = cost;
        nwr       = 0;
        max_addr  = 0;
        done_seen = 1'b0;
        @(negedge Clk);
        bus.spr_x    = x;
        bus.spr_y    = y;
        bus.spr_base = b;
        bus.start    = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        acc_edge  = cyc;
        #1;
        check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic finish_draw(input bit chk_lat, input int extra, input string tag);
        for (int i = 0; i < 30000 && !done_seen; i++) @(negedge Clk);
        #2;
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done expected=done", tag);
        end else begin
            if (chk_lat) check({tag, "_done_cycle"}, done_cyc - acc_edge, exp_cost + extra);
            check({tag, "_write_count"}, nwr, exp_count);
            check({tag, "_queue_left"}, exp_addr.size(), 0);
            check({tag, "_busy_after"}, bus.busy, 0);
            check({tag, "_done_pulse"}, bus.done, 0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_fb_we"}, bus.fb_we, 0);
        check({tag, "_rom_addr"}, bus.rom_addr, 0);
        check({tag, "_fb_addr"}, bus.fb_addr, 0);
        check({tag, "_fb_data"}, bus.fb_data, 0);
    endtask

    task automatic wait_fb_we(input string tag);
        for (int i = 0; i < 50 && !bus.fb_we; i++) @(negedge Clk);
        check({tag, "_fb_we_seen"}, bus.fb_we, 1);
    endtask

    initial begin
        logic [18:0] a0;
        logic [7:0]  d0;

        for (int i = 0; i < 2048; i++) rom[i] = 8'd3;
        Reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.spr_x    = '0;
        bus.spr_y    = '0;
        bus.spr_base = '0;
        bus.fb_ready = 1'b0;

        // Reset with random inputs, including start.
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            bus.start    = 1'b1;
            bus.spr_x    = 10'($urandom);
            bus.spr_y    = 9'($urandom);
            bus.spr_base = 11'($urandom);
            bus.fb_ready = 1'($urandom);
            #1;
            check_zero_outputs("reset");
        end
        @(negedge Clk);
        bus.start = 1'b0;
        Reset_n   = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        check("idle_after_reset_busy", bus.busy, 0);

        ready_mode   = 0;
        bus.fb_ready = 1'b1;

        // All-opaque draw at the origin.
        begin_draw(10'd0, 9'd0, 11'd0);
        finish_draw(1'b1, 0, "opaque");
        check("opaque_writes", nwr, 1920);
        check("opaque_first_addr", first_addr, 0);
        check("opaque_last_addr", last_addr, 25007);
        check("opaque_latency", done_cyc - acc_edge + 1, 5761);

        // Alternate transparent / opaque columns.
        for (int i = 0; i < 2048; i++) rom[i] = (i % 2 == 0) ? 8'd7 : 8'd2;
        begin_draw(10'd0, 9'd0, 11'd0);
        finish_draw(1'b1, 0, "transp");
        check("transp_writes", nwr, 960);
        check("transp_latency", done_cyc - acc_edge + 1, 4801);

        // Bottom-right clipping.
        for (int i = 0; i < 2048; i++) rom[i] = 8'd3;
        begin_draw(10'd620, 9'd460, 11'd0);
        finish_draw(1'b1, 0, "clip");
        check("clip_writes", nwr, 400);
        check("clip_max_addr", max_addr, 307199);

        // Back-pressure on the first write plus an ignored start.
        ready_mode   = 2;
        bus.fb_ready = 1'b0;
        begin_draw(10'd100, 9'd50, 11'd5);
        wait_fb_we("bp");
        a0 = bus.fb_addr;
        d0 = bus.fb_data;
        check("bp_first_addr", a0, 19'(50 * 640 + 100));
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            if (i == 2) begin
                bus.start = 1'b1;
                bus.spr_x = 10'd300;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            check("bp_we_stable", bus.fb_we, 1);
            check("bp_addr_stable", bus.fb_addr, a0);
            check("bp_data_stable", bus.fb_data, d0);
            check("bp_one_write_only", nwr, 0);
            if (i == 5) begin
                ready_mode   = 0;
                bus.fb_ready = 1'b1;
            end
        end
        finish_draw(1'b1, 5, "bp");

        // Reset asserted during a WRITE.
        ready_mode   = 2;
        bus.fb_ready = 1'b0;
        begin_draw(10'd0, 9'd0, 11'd0);
        wait_fb_we("rst");
        Reset_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(negedge Clk);
        #1;
        check("midreset_no_done", bus.done, 0);
        @(negedge Clk);
        Reset_n      = 1'b1;
        ready_mode   = 0;
        bus.fb_ready = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        check("midreset_idle", bus.busy, 0);
        check("midreset_done_seen", done_seen, 0);
        begin_draw(10'd3, 9'd4, 11'd700);
        check("restart_rom_addr", bus.rom_addr, 700);
        finish_draw(1'b1, 0, "restart");

        // Randomised draws and ROM contents.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 2048; i++)
                rom[i] = ($urandom_range(0, 3) == 0) ? 8'd7 : 8'($urandom);
            ready_mode = (t == 1) ? 0 : 1;
            begin_draw(10'($urandom_range(0, 1023)), 9'($urandom_range(0, 511)), 11'($urandom));
            finish_draw(ready_mode == 0, 0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Reads a sprite from the synchronous sprite ROM (8-bit colour index per pixel, row-major) and writes its opaque pixels into the 640x480 colour-index frame buffer at a requested screen position. It is the consumer of the sprite ROM data path: it sits between game logic, which issues draw requests, and the frame-buffer write port. Colour index `TRANSP` is treated as transparent and is not written. Pixels that fall off the right or bottom screen edge are clipped.

## Interface
- `SPR_W`, 48, sprite width in pixels.
- `SPR_H`, 40, sprite height in rows. `SPR_W*SPR_H` must be ≤ 2048.
- `SCREEN_W`, 640, frame-buffer width.
- `SCREEN_H`, 480, frame-buffer height.
- `TRANSP`, 8'd7, transparent colour index.

- `Clk` in 1: single clock. All logic is rising-edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: draw request. Sampled only in IDLE.
- `spr_x` in 10: left screen column of the sprite. Latched on accept.
- `spr_y` in 9: top screen row of the sprite. Latched on accept.
- `spr_base` in 11: ROM address of sprite pixel (0,0). Latched on accept.
- `busy` out 1: high from the cycle after accept through DONE.
- `done` out 1: one-cycle pulse when the draw completes.
- `rom_addr` out 11: registered ROM address.
- `rom_data` in 8: ROM output, valid one cycle after `rom_addr` is presented.
- `fb_addr` out 19: frame-buffer address, equal to `y*SCREEN_W + x`.
- `fb_data` out 8: colour index to write.
- `fb_we` out 1: write request. Held until `fb_ready` is high.
- `fb_ready` in 1: the frame buffer accepts the write at an edge where `fb_we && fb_ready`.

## Operation
- States:
  - IDLE: `busy` = 0. On `start` = 1, latch the inputs, clear `row`/`col`, go to FETCH.
  - FETCH: `rom_addr` = `base + row*SPR_W + col`. Go to EVAL.
  - EVAL: `rom_data` is valid in this state; `rom_addr` is held.
    - If `rom_data == TRANSP`, or the pixel is clipped, advance.
    - Otherwise register `fb_addr`/`fb_data`, assert `fb_we`, go to WRITE.
  - WRITE: `fb_we` = 1. `fb_addr` and `fb_data` are stable while waiting. On `fb_ready` = 1, advance.
  - Advance:
    - If `col == SPR_W-1`: `col` = 0 and `row++`, otherwise `col++`.
    - After the last pixel (`row == SPR_H-1`, `col == SPR_W-1`) go to DONE, else go to FETCH.
  - DONE: `done` = 1 for one cycle, then go to IDLE.
- Clipping:
  - Compute `sx = x + col` and `sy = y + row` at 11 bits with no wrap.
  - The pixel is clipped if `sx >= SCREEN_W` or `sy >= SCREEN_H`.
  - Clipped pixels take the transparent path: no write, 2 cycles.
- Address arithmetic:
  - `fb_addr = sy*SCREEN_W + sx`, computed only for unclipped pixels, so it always fits 19 bits.
  - The ROM address is truncated to 11 bits.
- `start` in any state other than IDLE is ignored, including DONE. The latched inputs are never changed mid-draw.

## Timing
- Reset values: `busy` 0, `done` 0, `fb_we` 0, `rom_addr` 0, `fb_addr` 0, `fb_data` 0; state IDLE; counters 0.
- Start accepted at edge k: FETCH in cycle k+1, first `rom_data` valid in k+2, first `fb_we` in k+3 if that pixel is opaque.
- Cost per pixel with `fb_ready` tied high:
  - Opaque: 3 cycles.
  - Transparent or clipped: 2 cycles.
  - Each low cycle of `fb_ready` adds one cycle.
- `done` is asserted in the cycle after the final pixel's EVAL or WRITE completes. `busy` falls with `done`.
- Reset asserted mid-draw:
  - All outputs go to reset values immediately (asynchronously); an in-flight write is dropped.
  - After release the block is in IDLE and needs a new `start`.

## Structure
- Shared package `sprite_pkg`:
  - State enum `blit_state_t` (IDLE, FETCH, EVAL, WRITE, DONE).
  - `SCREEN_W`/`SCREEN_H` constants.
  - Default `TRANSP`.
  - Address widths `ROM_AW` = 11, `FB_AW` = 19.
- Sub-module `fb_addr_calc`:
  - Combinational clip flag and `sy*SCREEN_W + sx`, from the latched x/y and the counters.
  - The multiply is implemented as shift-add (`y*512 + y*128`).
- Top module holds the FSM, the row/col counters, the input latches and the output registers.

## Test plan
- Reset: hold `Reset_n` low with random inputs. Every output is 0; `start` during reset is ignored.
- All-opaque draw:
  - Stimulus: ROM returns 3 everywhere, x=0, y=0, base=0, `fb_ready`=1.
  - Response: 1920 writes; first `fb_addr` 0, last 25007, all `fb_data` 3.
  - `done` at cycle k+5761; `busy` high k+1..k+5761.
- Transparency:
  - Stimulus: ROM returns 7 on even columns and 2 on odd columns.
  - Response: exactly 960 writes, none with data 7; `done` at k+4801.
- Clipping:
  - x=620, y=460, all-opaque ROM.
  - Response: only cols 0..19 and rows 0..19 are written (400 writes); max `fb_addr` 479*640+639 = 307199; no address ≥ 307200.
- Back-pressure and ignored start:
  - Stimulus: `fb_ready` low for 5 cycles at the first write; pulse `start` mid-draw with new x.
  - Response: `fb_we`/`fb_addr`/`fb_data` stable for the 6 cycles; one write accepted; the draw uses the original x.
- Reset mid-draw:
  - Stimulus: drop `Reset_n` during WRITE.
  - Response: `fb_we` and `busy` fall before the next edge; no `done`. A new `start` restarts at row 0, col 0 with the first `rom_addr` = new base.
